// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM states,
// default vectors and the alignment helper.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0010;

    // True when the two low address bits respect the instruction alignment.
    // Only IALIGN values of 2 and 4 are meaningful.
    function automatic logic is_aligned(input logic [1:0] addr, input int unsigned ialign);
        if (ialign == 2) begin
            return (addr[0] == 1'b0);
        end
        return (addr == 2'b00);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Bus between the PC unit and its fetch / execute-control neighbours.
// master: the pipeline side that issues requests; slave: the PC unit.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            fetch_ready;
    logic            advance;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap;
    logic            mret;
    logic            halt_req;
    logic            resume;

    logic [XLEN-1:0] current_pc;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] bad_addr;
    logic            misaligned;
    logic            halted;

    modport master (
        output fetch_ready, advance, redirect_valid, redirect_target,
               trap, mret, halt_req, resume,
        input  current_pc, pc_valid, epc, bad_addr, misaligned, halted
    );

    modport slave (
        input  fetch_ready, advance, redirect_valid, redirect_target,
               trap, mret, halt_req, resume,
        output current_pc, pc_valid, epc, bad_addr, misaligned, halted
    );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority selector for the next fetch address.
// Produces next_pc plus the epc / bad_addr write enables and the
// misaligned-redirect event for the current state and requests.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     IALIGN      = 4
) (
    input  pc_state_e       state,
    input  logic [XLEN-1:0] current_pc,
    input  logic [XLEN-1:0] epc,
    input  logic            trap,
    input  logic            mret,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    input  logic            advance,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] next_pc,
    output logic            epc_we,
    output logic            bad_addr_we,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);

    logic target_ok;
    assign target_ok = is_aligned(redirect_target[1:0], IALIGN);

    // Priority mux: trap > mret > misaligned redirect > redirect > halt > advance > hold.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        next_pc     = current_pc;
        epc_we      = 1'b0;
        bad_addr_we = 1'b0;
        misaligned  = 1'b0;
        unique case (state)
            RUN: begin
                if (trap) begin
                    next_pc = TRAP_VECTOR;
                    epc_we  = 1'b1;
                end else if (mret) begin
                    next_pc = epc;
                end else if (redirect_valid && !target_ok) begin
                    next_pc     = TRAP_VECTOR;
                    epc_we      = 1'b1;
                    bad_addr_we = 1'b1;
                    misaligned  = 1'b1;
                end else if (redirect_valid) begin
                    next_pc = redirect_target;
                end else if (halt_req) begin
                    // Entering HALT freezes the address even if advance is set.
                    next_pc = current_pc;
                end else if (advance && fetch_ready) begin
                    next_pc = current_pc + STEP;
                end
            end
            HALT: begin
                if (trap) begin
                    next_pc = TRAP_VECTOR;
                    epc_we  = 1'b1;
                end
            end
            default: begin
                next_pc = current_pc;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencing, registered fetch
// address, exception PC and misaligned-target capture.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     IALIGN       = 4
) (
    input logic       clock,
    input logic       reset,
    pc_unit_if.slave  bus
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, epc_q, bad_addr_q;
    logic            misaligned_q;

    logic [XLEN-1:0] next_pc;
    logic            epc_we, bad_addr_we, misaligned_evt;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .IALIGN      (IALIGN)
    ) u_next_sel (
        .state           (state_q),
        .current_pc      (pc_q),
        .epc             (epc_q),
        .trap            (bus.trap),
        .mret            (bus.mret),
        .redirect_valid  (bus.redirect_valid),
        .redirect_target (bus.redirect_target),
        .halt_req        (bus.halt_req),
        .advance         (bus.advance),
        .fetch_ready     (bus.fetch_ready),
        .next_pc         (next_pc),
        .epc_we          (epc_we),
        .bad_addr_we     (bad_addr_we),
        .misaligned      (misaligned_evt)
    );

    // Next-state logic: BOOT lasts one cycle; halt only when no control transfer is pending.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.halt_req && !bus.trap && !bus.mret && !bus.redirect_valid) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // resume wins over a still-asserted halt_req.
                if (bus.trap || bus.resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and datapath registers; synchronous reset overrides any pending event.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            bad_addr_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= next_pc;
            misaligned_q <= misaligned_evt;
            if (epc_we) begin
                epc_q <= pc_q;
            end
            if (bad_addr_we) begin
                bad_addr_q <= bus.redirect_target;
            end
        end
    end

    assign bus.current_pc = pc_q;
    assign bus.epc        = epc_q;
    assign bus.bad_addr   = bad_addr_q;
    assign bus.misaligned = misaligned_q;
    assign bus.pc_valid   = (state_q == RUN);
    assign bus.halted     = (state_q == HALT);

endmodule
